// File: rtl/tms9918_vram_pkg.sv
// tms9918_vram_pkg: shared owner tag, address width and write-buffer entry for the VRAM arbiter
package tms9918_vram_pkg;
  localparam int VRAM_ADDR_W = 14;
  typedef enum logic [1:0] {OWN_NONE, OWN_DISP, OWN_CPU_RD, OWN_CPU_WR} owner_t;
  typedef struct packed {
    logic [VRAM_ADDR_W-1:0] addr;
    logic [7:0] data;
  } wbuf_entry_t;
endpackage

// File: rtl/tms9918_vram_arbiter_if.sv
// tms9918_vram_arbiter_if: CPU, display and VRAM macro signals of the arbiter
interface tms9918_vram_arbiter_if import tms9918_vram_pkg::*; #(parameter int ADDR_W = VRAM_ADDR_W);
  logic cpu_read, cpu_write, cpu_read_ready, disp_req, disp_valid, ram_en, ram_we, wbuf_overflow;
  logic [ADDR_W-1:0] cpu_addr, disp_addr, ram_addr;
  logic [7:0] cpu_wdata, cpu_rdata, disp_rdata, ram_wdata, ram_rdata;
  modport slave (
    input cpu_read, cpu_write, cpu_addr, cpu_wdata, disp_req, disp_addr, ram_rdata,
    output cpu_rdata, cpu_read_ready, disp_rdata, disp_valid, ram_en, ram_we, ram_addr, ram_wdata, wbuf_overflow
  );
  modport master (
    output cpu_read, cpu_write, cpu_addr, cpu_wdata, disp_req, disp_addr, ram_rdata,
    input cpu_rdata, cpu_read_ready, disp_rdata, disp_valid, ram_en, ram_we, ram_addr, ram_wdata, wbuf_overflow
  );
endinterface

// File: rtl/tms9918_vram_wbuf.sv
// tms9918_vram_wbuf: CPU write FIFO; a pop in the same cycle frees a slot for a push, drops set sticky overflow
module tms9918_vram_wbuf import tms9918_vram_pkg::*; #(parameter int DEPTH = 2) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  wbuf_entry_t din,
  output wbuf_entry_t dout,
  output logic        full,
  output logic        empty,
  output logic        overflow
);
  localparam int AW = $clog2(DEPTH);
  wbuf_entry_t mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_push = push && (!full || pop);
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wp <= wp + (AW+1)'(1);
      if (pop && !empty) rp <= rp + (AW+1)'(1);
      if (push && !do_push) overflow <= 1'b1;
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/tms9918_vram_arbiter.sv
// tms9918_vram_arbiter: single-port VRAM sharing, display priority with CPU starvation guard.
// TMS9918_ARB_STATS_EN adds cpu_wait_cycles / disp_miss_cnt saturating counters.
module tms9918_vram_arbiter import tms9918_vram_pkg::*; #(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int WBUF_DEPTH = 2,
  parameter int MAX_STALL = 8
) (
  input logic clk,
  input logic reset,
  tms9918_vram_arbiter_if.slave bus
`ifdef TMS9918_ARB_STATS_EN
  ,
  output logic [15:0] cpu_wait_cycles,
  output logic [15:0] disp_miss_cnt
`endif
);
  localparam int SW = $clog2(MAX_STALL + 1);
  owner_t gnt, tag;
  logic [SW-1:0] stall_cnt;
  logic rd_busy, rd_ok, cpu_pend, cpu_can, guard, cpu_gnt, wb_full, wb_empty;
  wbuf_entry_t head;
  tms9918_vram_wbuf #(.DEPTH(WBUF_DEPTH)) u_wbuf (
    .clk(clk), .reset(reset), .push(bus.cpu_write), .pop(gnt == OWN_CPU_WR),
    .din('{addr: VRAM_ADDR_W'(bus.cpu_addr), data: bus.cpu_wdata}),
    .dout(head), .full(wb_full), .empty(wb_empty), .overflow(bus.wbuf_overflow)
  );
  // a same-cycle write strobe must land in the buffer before any read may pass it
  assign rd_ok = bus.cpu_read && !rd_busy && wb_empty && !bus.cpu_write;
  assign cpu_pend = !wb_empty || (bus.cpu_read && !rd_busy);
  assign cpu_can = !wb_empty || rd_ok;
  assign guard = stall_cnt == SW'(MAX_STALL) && cpu_can;
  assign cpu_gnt = gnt == OWN_CPU_RD || gnt == OWN_CPU_WR;
  always_comb begin
    gnt = OWN_NONE;
    if (reset) gnt = OWN_NONE;
    else if (guard) gnt = wb_empty ? OWN_CPU_RD : OWN_CPU_WR;
    else if (bus.disp_req) gnt = OWN_DISP;
    else if (!wb_empty) gnt = OWN_CPU_WR;
    else if (rd_ok) gnt = OWN_CPU_RD;
    bus.ram_en = gnt != OWN_NONE;
    bus.ram_we = gnt == OWN_CPU_WR;
    bus.ram_addr = gnt == OWN_DISP ? bus.disp_addr : gnt == OWN_CPU_RD ? bus.cpu_addr :
                   gnt == OWN_CPU_WR ? ADDR_W'(head.addr) : '0;
    bus.ram_wdata = gnt == OWN_CPU_WR ? head.data : '0;
  end
  // read data returns one cycle after issue and is registered, so pulses trail the grant by two
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      tag <= OWN_NONE;
      rd_busy <= 1'b0;
      stall_cnt <= '0;
      bus.cpu_rdata <= '0;
      bus.cpu_read_ready <= 1'b0;
      bus.disp_rdata <= '0;
      bus.disp_valid <= 1'b0;
    end else begin
      tag <= gnt;
      rd_busy <= gnt == OWN_CPU_RD || (rd_busy && !bus.cpu_read_ready);
      stall_cnt <= (cpu_gnt || !cpu_pend) ? '0 :
                   (gnt == OWN_DISP && stall_cnt != SW'(MAX_STALL)) ? stall_cnt + SW'(1) : stall_cnt;
      bus.cpu_read_ready <= tag == OWN_CPU_RD;
      bus.disp_valid <= tag == OWN_DISP;
      if (tag == OWN_CPU_RD) bus.cpu_rdata <= bus.ram_rdata;
      if (tag == OWN_DISP) bus.disp_rdata <= bus.ram_rdata;
    end
`ifdef TMS9918_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cpu_wait_cycles <= '0;
      disp_miss_cnt <= '0;
    end else begin
      if (cpu_pend && !cpu_gnt && cpu_wait_cycles != 16'hFFFF) cpu_wait_cycles <= cpu_wait_cycles + 16'd1;
      if (guard && bus.disp_req && disp_miss_cnt != 16'hFFFF) disp_miss_cnt <= disp_miss_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_tms9918_vram_arbiter.sv
// tb_tms9918_vram_arbiter: directed scenarios plus random traffic against a cycle-level reference model
module tb_tms9918_vram_arbiter;
  import tms9918_vram_pkg::*;
  localparam int AW = 14, DEPTH = 2, MS = 8;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  tms9918_vram_arbiter_if #(.ADDR_W(AW)) bus();
`ifdef TMS9918_ARB_STATS_EN
  logic [15:0] cpu_wait_cycles, disp_miss_cnt;
`endif
  tms9918_vram_arbiter #(.ADDR_W(AW), .WBUF_DEPTH(DEPTH), .MAX_STALL(MS)) dut (
    .clk(clk), .reset(reset), .bus(bus)
`ifdef TMS9918_ARB_STATS_EN
    , .cpu_wait_cycles(cpu_wait_cycles), .disp_miss_cnt(disp_miss_cnt)
`endif
  );
  function automatic logic [7:0] hash(logic [AW-1:0] a);
    return a[7:0] ^ {a[13:8], 2'b10};
  endfunction
  logic [7:0] vram [1<<AW];
  bit vwr [1<<AW] = '{default: 1'b0};
  always @(posedge clk)
    if (bus.ram_en) begin
      if (bus.ram_we) begin
        vram[bus.ram_addr] <= bus.ram_wdata;
        vwr[bus.ram_addr] <= 1'b1;
      end else bus.ram_rdata <= vwr[bus.ram_addr] ? vram[bus.ram_addr] : hash(bus.ram_addr);
    end
  int errors = 0, checks = 0;
  logic [7:0] ref_mem [1<<AW];
  bit ref_wr [1<<AW] = '{default: 1'b0};
  logic [21:0] wq[$], obs_w[$];
  int cyc = 0, rd_free_at, stall, wait_cnt, miss_cnt, n_dv, ready_dv, n_rdy;
  bit ovf, exp_ready, obs_rd;
  bit ev_dv [4], ev_cr [4];
  logic [7:0] ev_dd [4], ev_cd [4];
  logic [7:0] hold_dd, hold_cd;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] ref_rd(logic [AW-1:0] a);
    return ref_wr[a] ? ref_mem[a] : hash(a);
  endfunction
  task automatic mreset();
    wq.delete();
    rd_free_at = 0; stall = 0; wait_cnt = 0; miss_cnt = 0; ovf = 0;
    hold_dd = '0; hold_cd = '0;
    for (int i = 0; i < 4; i++) begin ev_dv[i] = 0; ev_cr[i] = 0; end
  endtask
  task automatic chk_zero(string tag);
    chk({tag, "_ram_en"}, bus.ram_en, 0);
    chk({tag, "_ram_we"}, bus.ram_we, 0);
    chk({tag, "_ram_addr"}, bus.ram_addr, 0);
    chk({tag, "_ram_wdata"}, bus.ram_wdata, 0);
    chk({tag, "_cpu_rdata"}, bus.cpu_rdata, 0);
    chk({tag, "_cpu_ready"}, bus.cpu_read_ready, 0);
    chk({tag, "_disp_rdata"}, bus.disp_rdata, 0);
    chk({tag, "_disp_valid"}, bus.disp_valid, 0);
    chk({tag, "_overflow"}, bus.wbuf_overflow, 0);
  endtask
  // one clock of the reference: 0 none, 1 display, 2 cpu read, 3 cpu write
  task automatic cycle();
    bit rd_pend, rd_ok, can, pend;
    int g, s, s2;
    logic [21:0] h;
    @(negedge clk);
    rd_pend = bus.cpu_read && cyc >= rd_free_at;
    rd_ok = rd_pend && wq.size() == 0 && !bus.cpu_write;
    can = wq.size() != 0 || rd_ok;
    pend = wq.size() != 0 || rd_pend;
    g = (stall == MS && can) ? (wq.size() != 0 ? 3 : 2) : bus.disp_req ? 1 : wq.size() != 0 ? 3 : rd_ok ? 2 : 0;
    h = wq.size() != 0 ? wq[0] : '0;
    chk("ram_en", bus.ram_en, g != 0);
    chk("ram_we", bus.ram_we, g == 3);
    if (g != 0) chk("ram_addr", bus.ram_addr, g == 1 ? bus.disp_addr : g == 2 ? bus.cpu_addr : h[21:8]);
    if (g == 3) chk("ram_wdata", bus.ram_wdata, h[7:0]);
    s = cyc % 4;
    if (ev_dv[s]) hold_dd = ev_dd[s];
    if (ev_cr[s]) hold_cd = ev_cd[s];
    chk("disp_valid", bus.disp_valid, ev_dv[s]);
    chk("cpu_read_ready", bus.cpu_read_ready, ev_cr[s]);
    chk("disp_rdata", bus.disp_rdata, hold_dd);
    chk("cpu_rdata", bus.cpu_rdata, hold_cd);
    chk("wbuf_overflow", bus.wbuf_overflow, ovf);
    exp_ready = ev_cr[s];
    if (bus.cpu_read_ready) begin ready_dv = n_dv; n_rdy++; end
    if (bus.disp_valid) n_dv++;
    if (bus.ram_en && bus.ram_we) obs_w.push_back({bus.ram_addr, bus.ram_wdata});
    obs_rd = bus.ram_en && !bus.ram_we && bus.ram_addr == bus.cpu_addr && bus.disp_addr != bus.cpu_addr;
    ev_dv[s] = 0; ev_cr[s] = 0;
    if (pend && g < 2) wait_cnt++;
    if (stall == MS && can && bus.disp_req) miss_cnt++;
    stall = (g >= 2 || !pend) ? 0 : (g == 1 && stall < MS) ? stall + 1 : stall;
    s2 = (cyc + 2) % 4;
    if (g == 1) begin ev_dv[s2] = 1; ev_dd[s2] = ref_rd(bus.disp_addr); end
    if (g == 2) begin ev_cr[s2] = 1; ev_cd[s2] = ref_rd(bus.cpu_addr); rd_free_at = cyc + 3; end
    if (g == 3) begin
      void'(wq.pop_front());
      ref_mem[h[21:8]] = h[7:0];
      ref_wr[h[21:8]] = 1;
    end
    if (bus.cpu_write) begin
      if (wq.size() < DEPTH) wq.push_back({bus.cpu_addr, bus.cpu_wdata});
      else ovf = 1;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask
  task automatic rd_wait(string tag, int max);
    bit seen = 0;
    for (int i = 0; i < max && !seen; i++) begin
      cycle();
      seen = exp_ready;
    end
    bus.cpu_read = 0;
    if (!seen) chk({tag, "_timeout"}, 0, 1);
  endtask
  initial begin
    int first;
    bit rd_on, rd_cool, wr;
    logic [AW-1:0] rd_addr;
    bus.cpu_read = 0; bus.cpu_write = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.disp_req = 0; bus.disp_addr = '0;
    mreset();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    reset = 0;
    cycle();
    // 1: write then read back
    obs_w.delete();
    bus.cpu_write = 1; bus.cpu_addr = 14'h0123; bus.cpu_wdata = 8'hA5;
    cycle();
    bus.cpu_write = 0;
    cycle();
    chk("t1_write_issued", obs_w.size(), 1);
    bus.cpu_read = 1;
    rd_wait("t1", 6);
    chk("t1_rdata", bus.cpu_rdata, 8'hA5);
    repeat (3) cycle();
    chk("t1_rdata_held", bus.cpu_rdata, 8'hA5);
    // 2: continuous display with a pending read
    n_dv = 0; first = 0; ready_dv = -1;
    bus.cpu_addr = 14'h0040; bus.cpu_read = 1; bus.disp_req = 1;
    for (int i = 1; i <= 20 && !exp_ready; i++) begin
      bus.disp_addr = AW'(14'h2000 + i);
      cycle();
      if (obs_rd && first == 0) first = i;
    end
    bus.cpu_read = 0;
    chk("t2_grant_cycle", first, 9);
    chk("t2_disp_before_ready", ready_dv, 8);
`ifdef TMS9918_ARB_STATS_EN
    chk("t2_disp_miss", disp_miss_cnt, 1);
`endif
    bus.disp_req = 0;
    repeat (4) cycle();
    // 3: write overflow under display pressure
    obs_w.delete();
    bus.disp_req = 1;
    for (int i = 0; i < 3; i++) begin
      bus.cpu_write = 1; bus.cpu_addr = AW'(14'h10 + i); bus.cpu_wdata = 8'(i + 1);
      bus.disp_addr = AW'(14'h3000 + i);
      cycle();
    end
    bus.cpu_write = 0;
    cycle();
    chk("t3_overflow", bus.wbuf_overflow, 1);
    bus.disp_req = 0;
    repeat (4) cycle();
    chk("t3_writes", obs_w.size(), 2);
    if (obs_w.size() == 2) begin
      chk("t3_first", obs_w[0], {14'h0010, 8'h01});
      chk("t3_second", obs_w[1], {14'h0011, 8'h02});
    end
    // 4: write and read to the same address in one cycle
    bus.cpu_write = 1; bus.cpu_read = 1; bus.cpu_addr = 14'h3FFF; bus.cpu_wdata = 8'h11;
    cycle();
    bus.cpu_write = 0;
    rd_wait("t4", 8);
    chk("t4_rdata", bus.cpu_rdata, 8'h11);
    cycle();
    // 5: reset while a read is in flight
    bus.cpu_read = 1; bus.cpu_addr = 14'h0042;
    cycle();
    reset = 1;
    bus.disp_req = 1; bus.cpu_write = 1;
    #1;
    chk_zero("t5");
    mreset();
    @(posedge clk);
    #1;
    reset = 0; bus.disp_req = 0; bus.cpu_write = 0; bus.cpu_read = 0;
    n_rdy = 0;
    repeat (6) cycle();
    chk("t5_no_ready", n_rdy, 0);
    // 6: alternating display requests
    first = -1;
    bus.cpu_read = 1; bus.cpu_addr = 14'h0200; bus.disp_addr = 14'h1234;
    for (int i = 0; i < 12 && !exp_ready; i++) begin
      bus.disp_req = (i % 2) == 0;
      cycle();
      if (obs_rd && first < 0) first = i;
    end
    bus.cpu_read = 0; bus.disp_req = 0;
    chk("t6_grant_cycle", first, 1);
    cycle();
    // random traffic
    rd_on = 0; rd_cool = 0; rd_addr = '0;
    for (int i = 0; i < 800; i++) begin
      bus.disp_req = $urandom_range(0, 99) < 60;
      bus.disp_addr = AW'($urandom_range(0, 63));
      wr = $urandom_range(0, 99) < 15;
      if (!rd_on && !rd_cool && $urandom_range(0, 9) < 3) begin
        rd_on = 1;
        rd_addr = AW'($urandom_range(0, 31));
      end
      bus.cpu_read = rd_on;
      bus.cpu_write = wr;
      bus.cpu_addr = wr ? AW'($urandom_range(0, 31)) : rd_addr;
      bus.cpu_wdata = 8'($urandom);
      rd_cool = 0;
      cycle();
      if (exp_ready) begin rd_on = 0; rd_cool = 1; end
    end
    bus.cpu_read = 0; bus.cpu_write = 0; bus.disp_req = 0;
    repeat (4) cycle();
`ifdef TMS9918_ARB_STATS_EN
    chk("stats_wait", cpu_wait_cycles, wait_cnt);
    chk("stats_miss", disp_miss_cnt, miss_cnt);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
